// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and the ALU operation code.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       is_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_e     state_q, state_d;
  logic       is_store_q, is_store_d;
  logic       is_bne_q, is_bne_d;
  logic       funct_ok_s;
  logic [2:0] funct_alu_s;

  // State register plus the lw/sw and beq/bne flags captured in DECODE,
  // so later states never look at the opcode again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      is_bne_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      is_bne_q   <= is_bne_d;
    end
  end

  // R-type funct to ALU operation; unsupported functs are flagged.
  always_comb begin
    funct_ok_s  = 1'b1;
    funct_alu_s = 3'd0;
    case (funct)
      6'h20:   funct_alu_s = 3'd2;
      6'h22:   funct_alu_s = 3'd6;
      6'h24:   funct_alu_s = 3'd0;
      6'h25:   funct_alu_s = 3'd1;
      6'h2A:   funct_alu_s = 3'd7;
      default: funct_ok_s  = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    is_bne_d   = is_bne_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
        else           state_d = ST_FETCH;
      end
      ST_DECODE: begin
        is_store_d = (opcode == OP_SW);
        is_bne_d   = (opcode == OP_BNE);
        case (opcode)
          OP_LW, OP_SW:   state_d = ST_MEMADR;
          OP_RTYPE:       state_d = ST_EXEC;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_ADDI:        state_d = ST_ADDIEX;
          OP_J:           state_d = ST_JUMP;
          default:        state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        if (is_store_q) state_d = ST_MEMWR;
        else            state_d = ST_MEMRD;
      end
      ST_MEMRD: begin
        if (mem_ready) state_d = ST_MEMWB;
        else           state_d = ST_MEMRD;
      end
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR: begin
        if (mem_ready) state_d = ST_FETCH;
        else           state_d = ST_MEMWR;
      end
      ST_EXEC: begin
        if (funct_ok_s) state_d = ST_ALUWB;
        else            state_d = ST_FETCH;
      end
      ST_ALUWB:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode: Moore per state, with the memory handshake, branch
  // condition and illegal-instruction checks folded in where needed.
  always_comb begin
    mem_req     = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'd0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = 3'd2;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = 3'd2;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      ST_MEMADR, ST_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = 3'd2;
      end
      ST_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        if (funct_ok_s) begin
          alu_control = funct_alu_s;
        end else begin
          illegal = 1'b1;
        end
      end
      ST_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 3'd6;
        pc_src      = 2'b01;
        instr_done  = 1'b1;
        if (is_bne_q) pc_en = !is_zero;
        else          pc_en = is_zero;
      end
      ST_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      default: mem_req = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: each cycle's full output vector is
// compared against a hand-built expectation.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_zero;
  logic       mem_ready;
  logic       mem_req, iord, mem_write, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal;

  int n_chk;
  int n_fail;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .is_zero(is_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: mem_req iord mem_write ir_write pc_en pc_src[2] alu_src_a
  // alu_src_b[2] alu_control[3] reg_dst mem_to_reg reg_write instr_done illegal
  localparam logic [17:0] V_ZERO       = 18'd0;
  localparam logic [17:0] V_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,3'd2,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_FETCH_WAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,3'd2,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'd2,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_DECODE_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'd2,1'b0,1'b0,1'b0,1'b0,1'b1};
  localparam logic [17:0] V_EXEC_SUB   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,3'd6,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_EXEC_AND   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_EXEC_OR    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,3'd1,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_EXEC_SLT   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,3'd7,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_EXEC_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1};
  localparam logic [17:0] V_ALUWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'd0,1'b1,1'b0,1'b1,1'b1,1'b0};
  localparam logic [17:0] V_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'd2,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_MEMRD      = {1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'd0,1'b0,1'b1,1'b1,1'b1,1'b0};
  localparam logic [17:0] V_MEMWR_WAIT = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_MEMWR_RDY  = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'd0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [17:0] V_BR_TAKEN   = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,3'd6,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [17:0] V_BR_NOT     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,3'd6,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [17:0] V_ADDIWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'd0,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam logic [17:0] V_JUMP       = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'd0,1'b0,1'b0,1'b0,1'b1,1'b0};

  logic [17:0] obs_s;
  assign obs_s = {mem_req, iord, mem_write, ir_write, pc_en, pc_src, alu_src_a,
                  alu_src_b, alu_control, reg_dst, mem_to_reg, reg_write,
                  instr_done, illegal};

  task automatic chk(input string tag, input logic [17:0] exp);
    n_chk++;
    assert (obs_s === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs_s, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, check outputs 1ns later.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                      input logic iz, input logic [17:0] exp, input string tag);
    @(negedge clk);
    opcode    = op;
    funct     = fn;
    mem_ready = mr;
    is_zero   = iz;
    #1;
    chk(tag, exp);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h00;
    is_zero   = 1'b0;
    mem_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1 chk("reset_hold", V_ZERO);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(6'h00, 6'h22, 1'b1, 1'b0, V_ZERO,      "idle_after_reset");
    // R-type sub: four cycles, done on the fourth
    step(6'h00, 6'h22, 1'b1, 1'b0, V_FETCH_RDY, "sub_fetch");
    step(6'h00, 6'h22, 1'b1, 1'b0, V_DECODE,    "sub_decode");
    step(6'h00, 6'h22, 1'b1, 1'b0, V_EXEC_SUB,  "sub_exec");
    step(6'h00, 6'h22, 1'b1, 1'b0, V_ALUWB,     "sub_aluwb");
    // lw with two wait cycles in MEMRD: seven cycles
    step(6'h23, 6'h00, 1'b1, 1'b0, V_FETCH_RDY, "lw_fetch");
    step(6'h23, 6'h00, 1'b1, 1'b0, V_DECODE,    "lw_decode");
    step(6'h23, 6'h00, 1'b1, 1'b0, V_MEMADR,    "lw_memadr");
    step(6'h23, 6'h00, 1'b0, 1'b0, V_MEMRD,     "lw_memrd_wait1");
    step(6'h23, 6'h00, 1'b0, 1'b0, V_MEMRD,     "lw_memrd_wait2");
    step(6'h23, 6'h00, 1'b1, 1'b0, V_MEMRD,     "lw_memrd_rdy");
    step(6'h23, 6'h00, 1'b1, 1'b0, V_MEMWB,     "lw_memwb");
    // sw with a fetch stall and two MEMWR waits
    step(6'h2B, 6'h00, 1'b0, 1'b0, V_FETCH_WAIT, "sw_fetch_wait");
    step(6'h2B, 6'h00, 1'b1, 1'b0, V_FETCH_RDY,  "sw_fetch_rdy");
    step(6'h2B, 6'h00, 1'b1, 1'b0, V_DECODE,     "sw_decode");
    step(6'h2B, 6'h00, 1'b1, 1'b0, V_MEMADR,     "sw_memadr");
    step(6'h2B, 6'h00, 1'b0, 1'b0, V_MEMWR_WAIT, "sw_memwr_wait1");
    step(6'h2B, 6'h00, 1'b0, 1'b0, V_MEMWR_WAIT, "sw_memwr_wait2");
    step(6'h2B, 6'h00, 1'b1, 1'b0, V_MEMWR_RDY,  "sw_memwr_rdy");
    // beq taken / not taken
    step(6'h04, 6'h00, 1'b1, 1'b0, V_FETCH_RDY, "beq1_fetch");
    step(6'h04, 6'h00, 1'b1, 1'b0, V_DECODE,    "beq1_decode");
    step(6'h04, 6'h00, 1'b1, 1'b1, V_BR_TAKEN,  "beq_taken");
    step(6'h04, 6'h00, 1'b1, 1'b1, V_FETCH_RDY, "beq2_fetch");
    step(6'h04, 6'h00, 1'b1, 1'b1, V_DECODE,    "beq2_decode");
    step(6'h04, 6'h00, 1'b1, 1'b0, V_BR_NOT,    "beq_not_taken");
    // bne inverts the condition
    step(6'h05, 6'h00, 1'b1, 1'b1, V_FETCH_RDY, "bne1_fetch");
    step(6'h05, 6'h00, 1'b1, 1'b1, V_DECODE,    "bne1_decode");
    step(6'h05, 6'h00, 1'b1, 1'b0, V_BR_TAKEN,  "bne_taken");
    step(6'h05, 6'h00, 1'b1, 1'b0, V_FETCH_RDY, "bne2_fetch");
    step(6'h05, 6'h00, 1'b1, 1'b0, V_DECODE,    "bne2_decode");
    step(6'h05, 6'h00, 1'b1, 1'b1, V_BR_NOT,    "bne_not_taken");
    // addi
    step(6'h08, 6'h00, 1'b1, 1'b0, V_FETCH_RDY, "addi_fetch");
    step(6'h08, 6'h00, 1'b1, 1'b0, V_DECODE,    "addi_decode");
    step(6'h08, 6'h00, 1'b1, 1'b0, V_MEMADR,    "addi_exec");
    step(6'h08, 6'h00, 1'b1, 1'b0, V_ADDIWB,    "addi_wb");
    // j
    step(6'h02, 6'h00, 1'b1, 1'b0, V_FETCH_RDY, "j_fetch");
    step(6'h02, 6'h00, 1'b1, 1'b0, V_DECODE,    "j_decode");
    step(6'h02, 6'h00, 1'b1, 1'b0, V_JUMP,      "j_jump");
    // illegal opcode: two cycles, back to FETCH
    step(6'h3F, 6'h00, 1'b1, 1'b0, V_FETCH_RDY,  "illop_fetch");
    step(6'h3F, 6'h00, 1'b1, 1'b0, V_DECODE_ILL, "illop_decode");
    // illegal funct: three cycles, no ALUWB
    step(6'h00, 6'h00, 1'b1, 1'b0, V_FETCH_RDY, "illfn_fetch");
    step(6'h00, 6'h00, 1'b1, 1'b0, V_DECODE,    "illfn_decode");
    step(6'h00, 6'h00, 1'b1, 1'b0, V_EXEC_ILL,  "illfn_exec");
    // remaining functs
    step(6'h00, 6'h24, 1'b1, 1'b0, V_FETCH_RDY, "and_fetch");
    step(6'h00, 6'h24, 1'b1, 1'b0, V_DECODE,    "and_decode");
    step(6'h00, 6'h24, 1'b1, 1'b0, V_EXEC_AND,  "and_exec");
    step(6'h00, 6'h24, 1'b1, 1'b0, V_ALUWB,     "and_aluwb");
    step(6'h00, 6'h25, 1'b1, 1'b0, V_FETCH_RDY, "or_fetch");
    step(6'h00, 6'h25, 1'b1, 1'b0, V_DECODE,    "or_decode");
    step(6'h00, 6'h25, 1'b1, 1'b0, V_EXEC_OR,   "or_exec");
    step(6'h00, 6'h25, 1'b1, 1'b0, V_ALUWB,     "or_aluwb");
    step(6'h00, 6'h2A, 1'b1, 1'b0, V_FETCH_RDY, "slt_fetch");
    step(6'h00, 6'h2A, 1'b1, 1'b0, V_DECODE,    "slt_decode");
    step(6'h00, 6'h2A, 1'b1, 1'b0, V_EXEC_SLT,  "slt_exec");
    step(6'h00, 6'h2A, 1'b1, 1'b0, V_ALUWB,     "slt_aluwb");
    // reset in the middle of a stalled store
    step(6'h2B, 6'h00, 1'b1, 1'b0, V_FETCH_RDY,  "rsw_fetch");
    step(6'h2B, 6'h00, 1'b1, 1'b0, V_DECODE,     "rsw_decode");
    step(6'h2B, 6'h00, 1'b1, 1'b0, V_MEMADR,     "rsw_memadr");
    step(6'h2B, 6'h00, 1'b0, 1'b0, V_MEMWR_WAIT, "rsw_memwr_wait");
    #2 rst_n = 1'b0;
    #1 chk("rsw_reset_async", V_ZERO);
    @(posedge clk);
    #1 chk("rsw_reset_held", V_ZERO);
    rst_n = 1'b1;
    step(6'h00, 6'h20, 1'b1, 1'b0, V_ZERO,      "rsw_idle");
    step(6'h00, 6'h20, 1'b1, 1'b0, V_FETCH_RDY, "rsw_refetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
